// File: rtl/fe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fe_pkg
// Description : Shared front-end types for the multi-cycle RV32I(+MUL) core.
// Revision    : 1.0 - initial release
// ============================================================================
package fe_pkg;

    typedef enum logic [6:0] {
        R_TYPE       = 7'b0110011,
        I_TYPE       = 7'b0010011,
        I_LOAD_TYPE  = 7'b0000011,
        I_JALR_TYPE  = 7'b1100111,
        I_ENV_TYPE   = 7'b1110011,
        S_TYPE       = 7'b0100011,
        B_TYPE       = 7'b1100011,
        U_LUI_TYPE   = 7'b0110111,
        U_AUIPC_TYPE = 7'b0010111,
        J_TYPE       = 7'b1101111
    } RV32I_OPCODE_t;

    typedef enum logic [1:0] {
        PC_PLUS_4   = 2'd0,
        PC_PLUS_IMM = 2'd1,
        ALU_OUT     = 2'd2
    } PC_INPUT_SELECTOR_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } CTRL_STATE_t;

    localparam logic [6:0] c_funct7_base = 7'b0000000;
    localparam logic [6:0] c_funct7_alt  = 7'b0100000;
    localparam logic [6:0] c_mul_funct7  = 7'b0000001;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            R_TYPE, I_TYPE, I_LOAD_TYPE, I_JALR_TYPE, I_ENV_TYPE,
            S_TYPE, B_TYPE, U_LUI_TYPE, U_AUIPC_TYPE, J_TYPE: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mc_wait_counter
// Description : Saturating up-counter with clear, enable and terminal compare.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_counter #(
    parameter int LAST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int c_width = (LAST < 1) ? 1 : $clog2(LAST + 1);
    localparam logic [c_width-1:0] c_last = c_width'(LAST);

    logic [c_width-1:0] r_count;

    // Holds at the terminal value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit
    import fe_pkg::*;
#(
    parameter int MUL_LATENCY    = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_is_fetch_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic [1:0] pc_sel_o,
    output logic       reg_write_o,
    output logic [2:0] state_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic       halt_o
);

    CTRL_STATE_t        r_state;
    CTRL_STATE_t        w_state_next;
    PC_INPUT_SELECTOR_t w_pc_sel;
    logic r_illegal, r_bus_err, r_halt;
    logic w_set_illegal, w_set_bus_err, w_set_halt;
    logic w_mem_phase, w_is_mul, w_is_store, w_bad_funct7, w_exec_last;
    logic w_state_change, w_timeout_last, w_mul_last;
    logic w_unused_funct3;

    // funct3 only selects ALU/memory variants in the datapath.
    assign w_unused_funct3 = ^funct3_i;

    assign w_mem_phase  = (r_state == FETCH) || (r_state == MEM);
    assign w_is_mul     = (opcode_i == R_TYPE) && (funct7_i == c_mul_funct7);
    assign w_is_store   = (opcode_i == S_TYPE);
    assign w_bad_funct7 = (opcode_i == R_TYPE) && (funct7_i != c_funct7_base)
                          && (funct7_i != c_funct7_alt) && (funct7_i != c_mul_funct7);
    assign w_exec_last  = !w_is_mul || w_mul_last;

    // Any transition restarts both counters, so each FETCH/MEM/EXECUTE visit starts at 0.
    assign w_state_change = (w_state_next != r_state);

    mc_wait_counter #(.LAST(TIMEOUT_CYCLES - 1)) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_state_change),
        .i_enable (w_mem_phase && !mem_ready_i),
        .o_done   (w_timeout_last)
    );

    mc_wait_counter #(.LAST(MUL_LATENCY - 1)) u_mul_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_state_change),
        .i_enable ((r_state == EXECUTE) && w_is_mul),
        .o_done   (w_mul_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_halt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
            if (w_set_halt)    r_halt    <= 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_is_fetch_o = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        branch_o       = 1'b0;
        reg_write_o    = 1'b0;
        w_pc_sel       = PC_PLUS_4;
        w_set_illegal  = 1'b0;
        w_set_bus_err  = 1'b0;
        w_set_halt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (run_i) w_state_next = FETCH;
            end
            FETCH: begin
                mem_req_o      = 1'b1;
                mem_is_fetch_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    w_state_next = DECODE;
                end else if (w_timeout_last) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = TRAP;
                end
            end
            DECODE: begin
                if (!is_legal_opcode(opcode_i) || w_bad_funct7) begin
                    w_set_illegal = 1'b1;
                    w_state_next  = TRAP;
                end else if (opcode_i == I_ENV_TYPE) begin
                    w_set_halt   = 1'b1;
                    w_state_next = TRAP;
                end else begin
                    w_state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                // Multiplies stay here until the latency counter reaches its end.
                if (w_exec_last) begin
                    case (opcode_i)
                        I_LOAD_TYPE, S_TYPE: w_state_next = MEM;
                        B_TYPE: begin
                            branch_o     = 1'b1;
                            w_pc_sel     = PC_PLUS_IMM;
                            w_state_next = FETCH;
                        end
                        J_TYPE: begin
                            pc_write_o   = 1'b1;
                            w_pc_sel     = PC_PLUS_IMM;
                            w_state_next = WRITEBACK;
                        end
                        I_JALR_TYPE: begin
                            pc_write_o   = 1'b1;
                            w_pc_sel     = ALU_OUT;
                            w_state_next = WRITEBACK;
                        end
                        default: w_state_next = WRITEBACK;
                    endcase
                end
            end
            MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = w_is_store;
                if (mem_ready_i) begin
                    w_state_next = w_is_store ? FETCH : WRITEBACK;
                end else if (w_timeout_last) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = TRAP;
                end
            end
            WRITEBACK: begin
                reg_write_o  = 1'b1;
                w_state_next = FETCH;
            end
            TRAP: begin
                w_state_next = TRAP;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign pc_sel_o  = w_pc_sel;
    assign state_o   = r_state;
    assign illegal_o = r_illegal;
    assign bus_err_o = r_bus_err;
    assign halt_o    = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Directed self-checking bench for mc_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst, run, mem_ready;
    logic       rst_to, run_to, ready_to;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    logic       mem_req, mem_we, mem_is_fetch, ir_write, pc_write, branch, reg_write;
    logic       illegal, bus_err, halt;
    logic [1:0] pc_sel;
    logic [2:0] state;

    logic       t_mem_req, t_mem_we, t_mem_is_fetch, t_ir_write, t_pc_write, t_branch;
    logic       t_reg_write, t_illegal, t_bus_err, t_halt;
    logic [1:0] t_pc_sel;
    logic [2:0] t_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.MUL_LATENCY(3), .TIMEOUT_CYCLES(15)) u_dut (
        .clk(clk), .rst(rst), .run_i(run), .opcode_i(opcode), .funct3_i(funct3),
        .funct7_i(funct7), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_is_fetch_o(mem_is_fetch), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .branch_o(branch), .pc_sel_o(pc_sel), .reg_write_o(reg_write), .state_o(state),
        .illegal_o(illegal), .bus_err_o(bus_err), .halt_o(halt)
    );

    mc_control_unit #(.MUL_LATENCY(3), .TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst(rst_to), .run_i(run_to), .opcode_i(opcode), .funct3_i(funct3),
        .funct7_i(funct7), .mem_ready_i(ready_to), .mem_req_o(t_mem_req), .mem_we_o(t_mem_we),
        .mem_is_fetch_o(t_mem_is_fetch), .ir_write_o(t_ir_write), .pc_write_o(t_pc_write),
        .branch_o(t_branch), .pc_sel_o(t_pc_sel), .reg_write_o(t_reg_write), .state_o(t_state),
        .illegal_o(t_illegal), .bus_err_o(t_bus_err), .halt_o(t_halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_to = 1'b1; run = 1'b0; run_to = 1'b0;
        mem_ready = 1'b0; ready_to = 1'b0;
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0000000;
        tick();
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_flags", {illegal, bus_err, halt}, 0);
        chk("rst_enables", {ir_write, pc_write, reg_write, branch, mem_we, mem_is_fetch}, 0);
        rst = 1'b0; rst_to = 1'b0;

        // addi with ready every cycle
        mem_ready = 1'b1; run = 1'b1;
        #1 chk("idle_state", state, 0);
        tick();
        chk("addi_c1_state", state, 1);
        chk("addi_c1_fetch", {mem_req, mem_is_fetch, ir_write, pc_write}, 4'b1111);
        chk("addi_c1_pcsel", pc_sel, 0);
        run = 1'b0;
        tick();
        chk("addi_c2_state", state, 2);
        chk("addi_c2_pcw", pc_write, 0);
        tick();
        chk("addi_c3_state", state, 3);
        chk("addi_c3_regw", reg_write, 0);
        tick();
        chk("addi_c4_state", state, 5);
        chk("addi_c4_regw", reg_write, 1);
        chk("addi_c4_pcw", pc_write, 0);
        tick();
        chk("addi_next_fetch", state, 1);

        // lw with three not-ready cycles in MEM
        opcode = 7'b0000011;
        tick();
        chk("lw_decode", state, 2);
        tick();
        chk("lw_exec", state, 3);
        mem_ready = 1'b0;
        tick();
        chk("lw_mem1", state, 4);
        chk("lw_mem1_req", {mem_req, mem_we, mem_is_fetch}, 3'b100);
        tick();
        chk("lw_mem2", state, 4);
        tick();
        chk("lw_mem3", state, 4);
        mem_ready = 1'b1;
        #1 chk("lw_mem4", state, 4);
        tick();
        chk("lw_wb", state, 5);
        chk("lw_buserr", bus_err, 0);
        tick();
        chk("lw_next_fetch", state, 1);

        // mul, three EXECUTE cycles
        opcode = 7'b0110011; funct7 = 7'b0000001;
        tick();
        chk("mul_decode", state, 2);
        tick();
        chk("mul_exec1", state, 3);
        tick();
        chk("mul_exec2", state, 3);
        tick();
        chk("mul_exec3", state, 3);
        chk("mul_exec3_en", {pc_write, reg_write, branch}, 0);
        tick();
        chk("mul_wb", state, 5);
        chk("mul_wb_regw", reg_write, 1);
        tick();
        chk("mul_done_fetch", state, 1);

        // branch
        opcode = 7'b1100011; funct7 = 7'b0000000;
        tick();
        chk("beq_decode", state, 2);
        tick();
        chk("beq_exec_branch", {branch, pc_write}, 2'b10);
        chk("beq_exec_pcsel", pc_sel, 1);
        tick();
        chk("beq_back_fetch", state, 1);

        // jalr
        opcode = 7'b1100111;
        tick();
        tick();
        chk("jalr_exec_pcw", {pc_write, branch}, 2'b10);
        chk("jalr_exec_pcsel", pc_sel, 2);
        tick();
        chk("jalr_wb", state, 5);
        tick();
        chk("jalr_fetch", state, 1);

        // store interrupted by reset in MEM
        opcode = 7'b0100011;
        tick();
        tick();
        chk("sw_exec", state, 3);
        mem_ready = 1'b0;
        tick();
        chk("sw_mem_req", {mem_req, mem_we}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("sw_rst_req", {mem_req, mem_we}, 2'b00);
        chk("sw_rst_state", state, 0);
        #2 rst = 1'b0;
        tick();
        chk("sw_post_rst_state", state, 0);
        chk("sw_post_rst_en", {mem_req, reg_write, pc_write}, 0);

        // illegal opcode 0000000
        opcode = 7'b0000000; mem_ready = 1'b1; run = 1'b1;
        tick();
        chk("ill_fetch", state, 1);
        run = 1'b0;
        tick();
        chk("ill_decode", state, 2);
        chk("ill_decode_flag", illegal, 0);
        tick();
        chk("ill_trap", state, 6);
        chk("ill_flags", {illegal, halt, bus_err}, 3'b100);
        chk("ill_trap_req", mem_req, 0);
        run = 1'b1;
        tick();
        chk("ill_trap_hold", state, 6);
        run = 1'b0;
        #2 rst = 1'b1;
        #1 chk("ill_rst_clear", illegal, 0);
        #2 rst = 1'b0;

        // ebreak
        opcode = 7'b1110011; run = 1'b1;
        tick();
        chk("ebrk_fetch", state, 1);
        run = 1'b0;
        tick();
        tick();
        chk("ebrk_trap", state, 6);
        chk("ebrk_flags", {illegal, halt}, 2'b01);

        // fetch timeout on the TIMEOUT_CYCLES=4 instance
        run_to = 1'b1; ready_to = 1'b0;
        tick();
        chk("to_c1", t_state, 1);
        chk("to_c1_req", t_mem_req, 1);
        run_to = 1'b0;
        tick();
        tick();
        tick();
        chk("to_c4", t_state, 1);
        chk("to_c4_flag", t_bus_err, 0);
        tick();
        chk("to_c5_trap", t_state, 6);
        chk("to_c5_flag", t_bus_err, 1);
        chk("to_c5_req", t_mem_req, 0);
        run_to = 1'b1; ready_to = 1'b1;
        tick();
        run_to = 1'b0;
        tick();
        chk("to_trap_hold", t_state, 6);
        chk("to_flag_hold", t_bus_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle control FSM for the RV32I(+MUL) core front-end. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared memory port with a ready handshake. It also adds configurable multiply latency, a memory-wait timeout and a sticky TRAP state. It sits between the instruction register/decoder and the datapath enables: register file, PC, IR and memory request.

## Interface
Parameters:
- MUL_LATENCY, 3: EXECUTE cycles for MUL (R_TYPE, funct7=0000001); legal range 1..15.
- TIMEOUT_CYCLES, 15: consecutive not-ready cycles tolerated in FETCH/MEM before a bus error; legal range 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- run_i  in  1  leave IDLE.
- opcode_i  in  7  IR[6:0].
- funct3_i  in  3  IR[14:12].
- funct7_i  in  7  IR[31:25].
- mem_ready_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  store request.
- mem_is_fetch_o  out  1  address from PC (1) or ALU (0).
- ir_write_o  out  1  capture instruction and old PC.
- pc_write_o  out  1  unconditional PC update.
- branch_o  out  1  conditional PC update, qualified by the ALU flag in the datapath.
- pc_sel_o  out  2  PC_INPUT_SELECTOR_t.
- reg_write_o  out  1  register-file write.
- state_o  out  3  current state.
- illegal_o  out  1  sticky illegal-instruction flag.
- bus_err_o  out  1  sticky memory-timeout flag.
- halt_o  out  1  sticky ECALL/EBREAK flag.

## Operation
States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.

- **Reset:** state IDLE; every output 0; pc_sel_o=PC_PLUS_4; wait and mul counters 0.
- **IDLE:** run_i=1 -> FETCH.
- **FETCH:** mem_req_o=1, mem_is_fetch_o=1.
  - On mem_ready_i: ir_write_o=1 and pc_write_o=1 with PC_PLUS_4 in that same cycle, then -> DECODE.
- **DECODE:** one cycle, priority order:
  - Opcode not in RV32I_OPCODE_t, or R_TYPE with funct7 not in {0000000, 0100000, 0000001}: -> TRAP and set illegal_o.
  - I_ENV_TYPE: -> TRAP and set halt_o.
  - Otherwise -> EXECUTE.
- **EXECUTE:** one cycle, or MUL_LATENCY cycles for MUL (mul counter counts 0..MUL_LATENCY-1). Next state depends on opcode:
  - R/I/U: -> WRITEBACK.
  - I_LOAD_TYPE, S_TYPE: -> MEM.
  - B_TYPE: branch_o=1, PC_PLUS_IMM -> FETCH.
  - J_TYPE: pc_write_o=1, PC_PLUS_IMM -> WRITEBACK.
  - I_JALR_TYPE: pc_write_o=1, ALU_OUT -> WRITEBACK.
  - PC controls are asserted only in the final EXECUTE cycle.
- **MEM:** mem_req_o=1, mem_we_o=1 for S_TYPE.
  - On ready: a load goes -> WRITEBACK; a store goes -> FETCH.
- **WRITEBACK:** reg_write_o=1 for one cycle -> FETCH.
- **Timeout:** the wait counter clears on every entry to FETCH/MEM.
  - Each cycle in FETCH/MEM with mem_ready_i=0: if count==TIMEOUT_CYCLES-1, go -> TRAP and set bus_err_o; else increment.
  - mem_ready_i=1 always wins over the timeout in the same cycle.
- **TRAP:** all enables 0; the flags hold; TRAP exits only via rst. run_i is ignored outside IDLE.

## Timing
- Outputs are decoded from state, except ir_write_o/pc_write_o in FETCH, which are gated by mem_ready_i (Mealy).
- Cycle counts with zero wait states:
  - ALU op: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - JAL/JALR: 4.
  - MUL: 3+MUL_LATENCY.
- Each wait cycle adds 1. The trap is entered on cycle TIMEOUT_CYCLES+1 after the request began.
- Reset is asynchronous mid-instruction: outputs drop to reset values immediately, with no partial writes after deassertion.
- Counters are $clog2(max+1) bits wide and never wrap.

## Structure
- fe_pkg holds:
  - RV32I_OPCODE_t.
  - PC_INPUT_SELECTOR_t with explicit 2-bit encoding: PC_PLUS_4=0, PC_PLUS_IMM=1, ALU_OUT=2.
  - A new CTRL_STATE_t as a logic[2:0] enum with the encodings above.
  - The MUL funct7 constant.
- One sub-module, mc_wait_counter: clear, enable and terminal-count compare. It is instantiated twice, once for timeout and once for the multiply.

## Test plan
- addi, ready every cycle -> states 1,2,3,5,1; reg_write_o high exactly in cycle 4; pc_write_o only in cycle 1.
- lw with mem_ready_i low for 3 cycles in MEM, TIMEOUT_CYCLES=15 -> MEM lasts 4 cycles; WRITEBACK follows; bus_err_o stays 0.
- Fetch with mem_ready_i held 0, TIMEOUT_CYCLES=4 -> TRAP entered 5 cycles after FETCH entry; bus_err_o=1; run_i toggling has no effect until rst.
- mul (funct7=0000001), MUL_LATENCY=3 -> EXECUTE lasts exactly 3 cycles; the instruction completes in 6 cycles.
- opcode 0000000 -> TRAP after DECODE with illegal_o=1; ebreak -> halt_o=1, illegal_o=0.
- rst asserted mid-MEM store -> mem_req_o/mem_we_o drop within the same cycle; state_o=0.
